// File: rtl/sdp_ram_pkg.sv
// Shared helpers for the simple dual-port RAM.
package sdp_ram_pkg;

    // Address width for a given word count, never narrower than one bit.
    function automatic int unsigned addr_w(input int unsigned size);
        if (size > 32'd1) begin
            return $clog2(size);
        end else begin
            return 32'd1;
        end
    endfunction

endpackage

// File: rtl/sdp_ram_if.sv
// Read/write port bundle of the simple dual-port RAM.
interface sdp_ram_if
    import sdp_ram_pkg::*;
#(
    parameter int unsigned WIDTH = 64,
    parameter int unsigned SIZE  = 1024
);
    localparam int unsigned AW = addr_w(SIZE);

    logic             rden;
    logic [AW-1:0]    rdaddr;
    logic [WIDTH-1:0] rddata;
    logic             wren;
    logic [AW-1:0]    wraddr;
    logic [WIDTH-1:0] wrdata;

    modport master (
        output rden,
        output rdaddr,
        input  rddata,
        output wren,
        output wraddr,
        output wrdata
    );

    modport slave (
        input  rden,
        input  rdaddr,
        output rddata,
        input  wren,
        input  wraddr,
        input  wrdata
    );

endinterface

// File: rtl/sdp_ram_outreg.sv
// Optional second read-data stage; loads only on an accepted read, async clear.
module sdp_ram_outreg #(
    parameter int unsigned WIDTH = 64
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_en,
    input  logic [WIDTH-1:0] i_d,
    output logic [WIDTH-1:0] o_q
);

    logic [WIDTH-1:0] r_q;

    // Pipeline register, holds when no read was accepted the cycle before.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_q <= '0;
        end else if (i_en) begin
            r_q <= i_d;
        end else begin
            r_q <= r_q;
        end
    end

    assign o_q = r_q;

endmodule

// File: rtl/sdp_ram.sv
// Simple dual-port RAM, one clock, registered read data.
// Define SDP_RAM_OUTREG_EN to add a second output stage (read latency 2).
module sdp_ram
    import sdp_ram_pkg::*;
#(
    parameter int unsigned WIDTH = 64,
    parameter int unsigned SIZE  = 1024
) (
    input  logic      clk,
    input  logic      rst_n,
    sdp_ram_if.slave  bus
);

    localparam int unsigned AW     = addr_w(SIZE);
    localparam logic [AW:0] SIZE_L = SIZE[AW:0];

    // Storage is deliberately left without reset so it maps onto block RAM.
    logic [WIDTH-1:0] r_mem [0:SIZE-1];
    logic [WIDTH-1:0] r_rddata;

    logic             w_wr_inrange;
    logic             w_rd_inrange;
    logic             w_collision;
    logic             w_wr_en;
    logic             w_rd_accept;
    logic [WIDTH-1:0] w_rd_next;

    assign w_wr_inrange = ({1'b0, bus.wraddr} < SIZE_L);
    assign w_rd_inrange = ({1'b0, bus.rdaddr} < SIZE_L);
    assign w_collision  = bus.rden && bus.wren && (bus.rdaddr == bus.wraddr);
    assign w_wr_en      = rst_n && bus.wren && w_wr_inrange;
    assign w_rd_accept  = bus.rden && !w_collision;

    // Out-of-range reads return zero instead of touching the array.
    always_comb begin
        w_rd_next = '0;
        if (w_rd_inrange) begin
            w_rd_next = r_mem[bus.rdaddr];
        end else begin
            w_rd_next = '0;
        end
    end

    // Write port into the storage array.
    always_ff @(posedge clk) begin
        if (w_wr_en) begin
            r_mem[bus.wraddr] <= bus.wrdata;
        end
    end

    // First read-data register; holds on idle cycles and suppressed collisions.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rddata <= '0;
        end else if (w_rd_accept) begin
            r_rddata <= w_rd_next;
        end else begin
            r_rddata <= r_rddata;
        end
    end

`ifdef SDP_RAM_OUTREG_EN
    logic r_rd_acc_d;

    // Remembers that r_rddata took a new word, so the next stage may advance.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rd_acc_d <= 1'b0;
        end else begin
            r_rd_acc_d <= w_rd_accept;
        end
    end

    sdp_ram_outreg #(
        .WIDTH (WIDTH)
    ) u_outreg (
        .clk   (clk),
        .rst_n (rst_n),
        .i_en  (r_rd_acc_d),
        .i_d   (r_rddata),
        .o_q   (bus.rddata)
    );
`else
    assign bus.rddata = r_rddata;
`endif

endmodule

// File: tb/tb_sdp_ram.sv
// Scoreboard bench for sdp_ram: a SIZE=16 and a SIZE=12 instance, WIDTH=8.
module tb_sdp_ram;

`ifdef SDP_RAM_OUTREG_EN
    localparam int LAT = 2;
`else
    localparam int LAT = 1;
`endif

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    always #5 clk = ~clk;

    sdp_ram_if #(.WIDTH(8), .SIZE(16)) if16 ();
    sdp_ram_if #(.WIDTH(8), .SIZE(12)) if12 ();

    sdp_ram #(.WIDTH(8), .SIZE(16)) u_dut16 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (if16.slave)
    );

    sdp_ram #(.WIDTH(8), .SIZE(12)) u_dut12 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (if12.slave)
    );

    int         checks = 0;
    int         errors = 0;
    logic [7:0] sb [$];
    logic [7:0] exp_v;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr16(input logic [3:0] a, input logic [7:0] d);
        if16.wren = 1'b1; if16.wraddr = a; if16.wrdata = d;
        tick();
        if16.wren = 1'b0;
    endtask

    task automatic rd16(input logic [3:0] a, input logic [7:0] e);
        sb.push_back(e);
        if16.rden = 1'b1; if16.rdaddr = a;
        tick();
        if16.rden = 1'b0;
        repeat (LAT - 1) tick();
    endtask

    task automatic wr12(input logic [3:0] a, input logic [7:0] d);
        if12.wren = 1'b1; if12.wraddr = a; if12.wrdata = d;
        tick();
        if12.wren = 1'b0;
    endtask

    task automatic rd12(input logic [3:0] a, input logic [7:0] e);
        sb.push_back(e);
        if12.rden = 1'b1; if12.rdaddr = a;
        tick();
        if12.rden = 1'b0;
        repeat (LAT - 1) tick();
    endtask

    task automatic test_reset();
        repeat (2) tick();
        checks++;
        if (if16.rddata !== 8'h00) begin
            errors++; $display("FAIL reset16 got=%h exp=%h", if16.rddata, 8'h00);
        end
        checks++;
        if (if12.rddata !== 8'h00) begin
            errors++; $display("FAIL reset12 got=%h exp=%h", if12.rddata, 8'h00);
        end
        rst_n = 1'b1;
        wr16(4'd3, 8'hA5);
        rd16(4'd3, 8'hA5);
        exp_v = sb.pop_front();
        checks++;
        if (if16.rddata !== exp_v) begin
            errors++; $display("FAIL pre_reset_rd got=%h exp=%h", if16.rddata, exp_v);
        end
        #3 rst_n = 1'b0;
        #1;
        checks++;
        if (if16.rddata !== 8'h00) begin
            errors++; $display("FAIL async_clear got=%h exp=%h", if16.rddata, 8'h00);
        end
        // write attempted under reset must be dropped
        wr16(4'd3, 8'h00);
        tick();
        rst_n = 1'b1;
        rd16(4'd3, 8'hA5);
        exp_v = sb.pop_front();
        checks++;
        if (if16.rddata !== exp_v) begin
            errors++; $display("FAIL mem_survives_reset got=%h exp=%h", if16.rddata, exp_v);
        end
    endtask

    task automatic test_basic();
        for (int i = 1; i <= 15; i++) begin
            wr16(4'(i), 8'(8'h10 + 8'(i)));
        end
        for (int t = 0; t < 15 + LAT - 1; t++) begin
            if (t < 15) begin
                if16.rden = 1'b1;
                if16.rdaddr = 4'(t + 1);
                sb.push_back(8'(8'h11 + 8'(t)));
            end else begin
                if16.rden = 1'b0;
            end
            tick();
            if (t >= LAT - 1) begin
                exp_v = sb.pop_front();
                checks++;
                if (if16.rddata !== exp_v) begin
                    errors++; $display("FAIL basic_rd t=%0d got=%h exp=%h", t, if16.rddata, exp_v);
                end
            end
        end
        if16.rden = 1'b0;
    endtask

    task automatic test_hold();
        rd16(4'd2, 8'h12);
        exp_v = sb.pop_front();
        checks++;
        if (if16.rddata !== exp_v) begin
            errors++; $display("FAIL hold_setup got=%h exp=%h", if16.rddata, exp_v);
        end
        for (int i = 0; i < 5; i++) begin
            if16.wren = 1'b1; if16.wraddr = 4'd5; if16.wrdata = 8'h55;
            tick();
            checks++;
            if (if16.rddata !== 8'h12) begin
                errors++; $display("FAIL hold cyc=%0d got=%h exp=%h", i, if16.rddata, 8'h12);
            end
        end
        if16.wren = 1'b0;
        rd16(4'd5, 8'h55);
        exp_v = sb.pop_front();
        checks++;
        if (if16.rddata !== exp_v) begin
            errors++; $display("FAIL hold_write_rd got=%h exp=%h", if16.rddata, exp_v);
        end
    endtask

    task automatic test_collision();
        rd16(4'd2, 8'h12);
        exp_v = sb.pop_front();
        checks++;
        if (if16.rddata !== exp_v) begin
            errors++; $display("FAIL coll_setup got=%h exp=%h", if16.rddata, exp_v);
        end
        sb.push_back(8'h12);
        if16.rden = 1'b1; if16.rdaddr = 4'd7;
        if16.wren = 1'b1; if16.wraddr = 4'd7; if16.wrdata = 8'h77;
        tick();
        if16.rden = 1'b0; if16.wren = 1'b0;
        repeat (LAT) tick();
        exp_v = sb.pop_front();
        checks++;
        if (if16.rddata !== exp_v) begin
            errors++; $display("FAIL coll_suppress got=%h exp=%h", if16.rddata, exp_v);
        end
        rd16(4'd7, 8'h77);
        exp_v = sb.pop_front();
        checks++;
        if (if16.rddata !== exp_v) begin
            errors++; $display("FAIL coll_newdata got=%h exp=%h", if16.rddata, exp_v);
        end
    endtask

    task automatic test_concurrent();
        sb.push_back(8'h14);
        if16.rden = 1'b1; if16.rdaddr = 4'd4;
        if16.wren = 1'b1; if16.wraddr = 4'd0; if16.wrdata = 8'hEE;
        tick();
        if16.rden = 1'b0; if16.wren = 1'b0;
        repeat (LAT - 1) tick();
        exp_v = sb.pop_front();
        checks++;
        if (if16.rddata !== exp_v) begin
            errors++; $display("FAIL conc_rd got=%h exp=%h", if16.rddata, exp_v);
        end
        rd16(4'd0, 8'hEE);
        exp_v = sb.pop_front();
        checks++;
        if (if16.rddata !== exp_v) begin
            errors++; $display("FAIL conc_wr got=%h exp=%h", if16.rddata, exp_v);
        end
    endtask

    task automatic test_boundary();
        wr12(4'd11, 8'hBB);
        wr12(4'd13, 8'hFF);
        rd12(4'd11, 8'hBB);
        exp_v = sb.pop_front();
        checks++;
        if (if12.rddata !== exp_v) begin
            errors++; $display("FAIL bnd_last got=%h exp=%h", if12.rddata, exp_v);
        end
        rd12(4'd13, 8'h00);
        exp_v = sb.pop_front();
        checks++;
        if (if12.rddata !== exp_v) begin
            errors++; $display("FAIL bnd_oor13 got=%h exp=%h", if12.rddata, exp_v);
        end
        rd12(4'd11, 8'hBB);
        exp_v = sb.pop_front();
        checks++;
        if (if12.rddata !== exp_v) begin
            errors++; $display("FAIL bnd_intact got=%h exp=%h", if12.rddata, exp_v);
        end
        rd12(4'd12, 8'h00);
        exp_v = sb.pop_front();
        checks++;
        if (if12.rddata !== exp_v) begin
            errors++; $display("FAIL bnd_oor12 got=%h exp=%h", if12.rddata, exp_v);
        end
    endtask

    initial begin
        if16.rden = 1'b0; if16.rdaddr = 4'd0;
        if16.wren = 1'b0; if16.wraddr = 4'd0; if16.wrdata = 8'h00;
        if12.rden = 1'b0; if12.rdaddr = 4'd0;
        if12.wren = 1'b0; if12.wraddr = 4'd0; if12.wrdata = 8'h00;
        test_reset();
        test_basic();
        test_hold();
        test_collision();
        test_concurrent();
        test_boundary();
        checks++;
        if (sb.size() !== 0) begin
            errors++; $display("FAIL sb_drain got=%0d exp=%0d", sb.size(), 0);
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/sdp_ram.md
Name: sdp_ram

Overview:
- Simple dual-port RAM: one write port and one read port, both on a single clock.
- Registered read data.
- Storage primitive under the team's FIFOs; the FIFO gates rden/wren with empty/full.
- Must infer block RAM: no reset on the storage array.

Parameters:
- WIDTH, default 64: data word width in bits.
- SIZE, default 1024: number of words; address width AW = $clog2(SIZE), minimum 1.

Ports:
- clk  input  1  single clock; all state changes on the rising edge.
- rst_n  input  1  asynchronous active-low reset.
- rden  input  1  read enable.
- rdaddr  input  AW  read address.
- rddata  output  WIDTH  registered read data.
- wren  input  1  write enable.
- wraddr  input  AW  write address.
- wrdata  input  WIDTH  write data.

Behaviour:
- Reset: rst_n low clears rddata to 0 immediately, without waiting for a clock edge. Release is synchronous in effect: the first capture happens on the first rising edge with rst_n high.
- Reset leaves memory contents untouched. Writes and reads are ignored while rst_n is low.
- Memory contents power up undefined; simulation may initialise them to 0.
- Write:
  - On a rising edge with wren=1 and wraddr<SIZE, mem[wraddr] <= wrdata.
  - wren=0: no change.
  - An out-of-range wraddr (only possible when SIZE is not a power of 2) is ignored.
- Read:
  - On a rising edge with rden=1, rddata <= mem[rdaddr]. Latency is 1 cycle.
  - rden=0: rddata holds its previous value.
  - An out-of-range rdaddr loads rddata with 0.
- Collision (rden=1, wren=1, rdaddr==wraddr on the same edge):
  - The write completes.
  - The read is suppressed and rddata holds its previous value.
  - A following read of that address returns the new data.
- Simultaneous read and write to different addresses: both complete independently in the same cycle.
- Addresses are not wrapped or modified. Callers manage wrap-around.
- No handshake, no backpressure, no status outputs.

Optional Feature:
- Macro: SDP_RAM_OUTREG_EN.
- Defined:
  - A second register stage follows rddata, giving read latency 2.
  - The stage advances only when a read was accepted in the previous cycle (a delayed rden, excluding suppressed collisions). Otherwise it holds.
  - The stage is cleared asynchronously by rst_n.
- Undefined: a single register, latency 1, exactly as above.
- Collision rule and out-of-range rule are identical in both builds.

Decomposition:
- No shared package is needed; AW is derived locally by $clog2.
- If the team package already exists, add an ADDR_W helper function there.
- One natural sub-module: sdp_ram_outreg, the optional pipeline register with async clear, instantiated only under SDP_RAM_OUTREG_EN.
- The storage array stays in the top module so block-RAM inference is reliable.

Test Plan:
- Reset: write mem[3]=0xA5 and read it (rddata=0xA5). Assert rst_n=0 mid-cycle → rddata=0 before the next edge. Release, read addr 3 → 0xA5 (contents survive reset).
- Basic write/read, SIZE=16, WIDTH=8: write 0x11..0x1F to addresses 1..15 → each read returns its value one cycle after the rden edge (two cycles with SDP_RAM_OUTREG_EN).
- Hold: read addr 2 (→0x12), then rden=0 for 5 cycles while writing addr 5=0x55 → rddata stays 0x12.
- Collision: rddata=0x12; same edge rden=1, wren=1, addr 7, wrdata=0x77 → rddata stays 0x12; next cycle read addr 7 → 0x77.
- Concurrent different addresses: write addr 0=0xEE while reading addr 4 (0x14) → rddata=0x14; next read addr 0 → 0xEE.
- Non-power-of-2 boundary, SIZE=12: write wraddr=13 with 0xFF → ignored; read 13 → 0; read 11 → previously written value intact.
